proj_fm_ring: RTL and testbench
===============================

// Module: proj_fm_ring
// PURPOSE
// - Successor to the two-buffer ping-pong fragment memory. N-deep ring of symbol buffers with a valid/ready write side.
// - Read side extracts fixed-length fragments at a signed symbol index, zero-padded outside [0, BUF_DEPTH).
// - Sits between the symbol stream source and the fragment extender / minhash datapath.
// - Writer and reader decouple by up to BUF_COUNT whole buffers.
// PARAMETERS
// BUF_COUNT  4                      number of ring buffers (power of 2, >=2)
// BUF_DEPTH  64                     symbols per buffer
// DATA_BITS  2                      bits per symbol
// FRAG_SYMS  16                     symbols per output fragment
// IDX_LEN    $clog2(BUF_DEPTH)+2    width of signed fragment index (two's complement)
// PORTS
// in_clk        in   1                    clock, all logic on rising edge
// in_rst        in   1                    synchronous reset, active-high
// in_wvalid     in   1                    write symbol valid
// in_wready     out  1                    a buffer slot is free for writing
// in_wdata      in   DATA_BITS            write symbol
// in_rd_req     in   1                    fragment read request
// in_frag_idx   in   IDX_LEN              signed start symbol index of the fragment
// in_release    in   1                    pulse: read buffer consumed, free it
// out_rd_avail  out  1                    at least one full buffer is readable
// out_rd_valid  out  1                    out_rdata valid (1 cycle after an accepted request)
// out_rdata     out  FRAG_SYMS*DATA_BITS  fragment; symbol i at [i*DATA_BITS +: DATA_BITS]
// out_rd_err    out  1                    pulse: request made with out_rd_avail=0
// out_full_cnt  out  $clog2(BUF_COUNT)+1  number of full, unreleased buffers
// BEHAVIOUR
// - Reset: wr_ptr=rd_ptr=0, waddr=0, full_cnt=0. All outputs 0 except in_wready=1. Memory contents are not reset.
// - In-flight read and partial buffer are discarded on reset. out_rd_valid is 0 in the cycle after reset.
// - Write:
//   - Accepted when in_wvalid & in_wready. Stores mem[wr_ptr][waddr].
//   - waddr increments; at waddr==BUF_DEPTH-1 it wraps to 0, wr_ptr advances (mod BUF_COUNT) and full_cnt increments.
//   - in_wready = (full_cnt < BUF_COUNT). When the ring is full, writes stall with no data loss.
// - Read:
//   - Request is accepted when in_rd_req & out_rd_avail. out_rd_avail = (full_cnt != 0).
//   - Next cycle: out_rd_valid=1, out_rdata computed from mem[rd_ptr].
//   - For each i in 0..FRAG_SYMS-1, with a = frag_idx + i evaluated signed at IDX_LEN+1 bits:
//     - symbol_i = mem[rd_ptr][a] if 0 <= a < BUF_DEPTH, else 0.
//   - Examples: frag_idx=-3 gives symbols 0..2 = 0. frag_idx=BUF_DEPTH-2 gives only symbols 0..1 from memory.
//   - out_rdata holds its last value when out_rd_valid=0.
//   - A request with out_rd_avail=0 gives out_rd_valid=0, out_rd_err=1 for one cycle, and out_rdata unchanged.
// - Release:
//   - in_release with full_cnt!=0 advances rd_ptr and decrements full_cnt. With full_cnt==0 it is ignored.
//   - A request in the same cycle as a release reads the old rd_ptr buffer.
// - Simultaneous buffer completion and release: full_cnt unchanged, both pointers advance.
// - Back-to-back requests are supported, one fragment per cycle.
// - Fully pipelined, no FSM beyond the pointer/count state. Read latency is exactly 1 cycle.
// CONFIGURATION
// - FM_OOB_FLAG_EN defined:
//   - Adds output out_oob (1 bit), valid with out_rd_valid.
//   - out_oob=1 iff any symbol of that fragment was zero-padded (frag_idx<0 or frag_idx+FRAG_SYMS>BUF_DEPTH).
//   - out_oob resets to 0.
// - FM_OOB_FLAG_EN undefined: the port does not exist. All other behaviour is identical.
// TESTING
// 1. Reset, write 64 symbols i%4 with wvalid held -> full_cnt=1, rd_avail=1; req idx=0 -> next cycle symbols 0,1,2,3,0,... rd_valid=1.
// 2. Buffer 0 full, req idx=-3 -> symbols 0..2 = 0, symbol 3 = mem[0] (=0), symbol 4 = mem[1] (=1); out_oob=1 when enabled.
// 3. Req idx=60 -> symbols 0..3 = mem[60..63] (0,1,2,3), symbols 4..15 = 0; idx=63-16+1=48 -> out_oob=0.
// 4. Write 4*64 symbols with no release -> in_wready=0 after the 256th accept; 257th symbol held; release -> wready=1 next cycle, symbol accepted.
// 5. Last write of buffer k and in_release in the same cycle -> full_cnt unchanged, rd_ptr and wr_ptr both +1.
// 6. Req with full_cnt=0 -> rd_err=1, rd_valid=0; assert in_rst mid-buffer (waddr=30) -> next cycle full_cnt=0, wready=1, rd_valid=0.

Source files
------------

// File: rtl/proj_fm_ring.sv
// proj_fm_ring: ring of BUF_COUNT symbol buffers with valid/ready writes and zero-padded fragment reads.
// Define FM_OOB_FLAG_EN to add out_oob, flagging fragments that contain padded symbols.
module proj_fm_ring #(
    parameter int BUF_COUNT = 4,
    parameter int BUF_DEPTH = 64,
    parameter int DATA_BITS = 2,
    parameter int FRAG_SYMS = 16,
    parameter int IDX_LEN   = $clog2(BUF_DEPTH) + 2
) (
    input  logic                           in_clk,
    input  logic                           in_rst,
    input  logic                           in_wvalid,
    output logic                           in_wready,
    input  logic [DATA_BITS-1:0]           in_wdata,
    input  logic                           in_rd_req,
    input  logic [IDX_LEN-1:0]             in_frag_idx,
    input  logic                           in_release,
    output logic                           out_rd_avail,
    output logic                           out_rd_valid,
    output logic [FRAG_SYMS*DATA_BITS-1:0] out_rdata,
    output logic                           out_rd_err,
    output logic [$clog2(BUF_COUNT):0]     out_full_cnt
`ifdef FM_OOB_FLAG_EN
    ,
    output logic                           out_oob
`endif
);
    localparam int PW = $clog2(BUF_COUNT);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_BITS-1:0]           mem [BUF_COUNT][BUF_DEPTH];
    logic [PW-1:0]                  wr_ptr, rd_ptr;
    logic [AW-1:0]                  waddr;
    logic [FRAG_SYMS-1:0]           in_rng;
    logic [FRAG_SYMS*DATA_BITS-1:0] frag;
    logic                           wr_fire, done, rel, rd_fire;

    assign in_wready    = out_full_cnt < CW'(BUF_COUNT);
    assign out_rd_avail = out_full_cnt != '0;
    assign wr_fire      = in_wvalid & in_wready;
    assign done         = wr_fire & (waddr == AW'(BUF_DEPTH - 1));
    assign rel          = in_release & out_rd_avail;
    assign rd_fire      = in_rd_req & out_rd_avail;

    // Sign-extend one bit so idx+i never wraps; in range iff the bits above the address are all zero.
    for (genvar i = 0; i < FRAG_SYMS; i++) begin : g_sym
        logic [IDX_LEN:0] a;
        assign a = {in_frag_idx[IDX_LEN-1], in_frag_idx} + (IDX_LEN+1)'(i);
        assign in_rng[i] = a[IDX_LEN:AW] == '0;
        assign frag[i*DATA_BITS +: DATA_BITS] = in_rng[i] ? mem[rd_ptr][a[AW-1:0]] : '0;
    end

    always_ff @(posedge in_clk)
        if (wr_fire && !in_rst)
            mem[wr_ptr][waddr] <= in_wdata;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            waddr        <= '0;
            out_full_cnt <= '0;
            out_rd_valid <= 1'b0;
            out_rd_err   <= 1'b0;
            out_rdata    <= '0;
        end else begin
            if (wr_fire)
                waddr <= done ? '0 : waddr + AW'(1);
            if (done)
                wr_ptr <= wr_ptr + PW'(1);
            if (rel)
                rd_ptr <= rd_ptr + PW'(1);
            out_full_cnt <= out_full_cnt + CW'(done) - CW'(rel);
            out_rd_valid <= rd_fire;
            out_rd_err   <= in_rd_req & ~out_rd_avail;
            if (rd_fire)
                out_rdata <= frag;
        end
    end

`ifdef FM_OOB_FLAG_EN
    always_ff @(posedge in_clk)
        if (in_rst)
            out_oob <= 1'b0;
        else if (rd_fire)
            out_oob <= ~&in_rng;
`endif
endmodule

// File: tb/tb_proj_fm_ring.sv
// tb_proj_fm_ring: directed checks of the fragment ring with hand-computed fragments.
module tb_proj_fm_ring;
    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_wvalid = 1'b0;
    logic        in_wready;
    logic [1:0]  in_wdata = '0;
    logic        in_rd_req = 1'b0;
    logic [7:0]  in_frag_idx = '0;
    logic        in_release = 1'b0;
    logic        out_rd_avail, out_rd_valid, out_rd_err;
    logic [31:0] out_rdata;
    logic [2:0]  out_full_cnt;
`ifdef FM_OOB_FLAG_EN
    logic        out_oob;
`endif
    int total = 0;
    int bad = 0;

    proj_fm_ring dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_wvalid(in_wvalid), .in_wready(in_wready),
        .in_wdata(in_wdata), .in_rd_req(in_rd_req), .in_frag_idx(in_frag_idx),
        .in_release(in_release), .out_rd_avail(out_rd_avail), .out_rd_valid(out_rd_valid),
        .out_rdata(out_rdata), .out_rd_err(out_rd_err), .out_full_cnt(out_full_cnt)
`ifdef FM_OOB_FLAG_EN
        , .out_oob(out_oob)
`endif
    );

    always #5 in_clk = ~in_clk;

    task automatic step;
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] idx, input logic rel, input string tag, input logic [31:0] exp);
        in_rd_req = 1'b1;
        in_frag_idx = idx;
        in_release = rel;
        step;
        in_rd_req = 1'b0;
        in_release = 1'b0;
        chk({tag, "_valid"}, 64'(out_rd_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_rdata), 64'(exp));
    endtask

    initial begin
        step;
        step;
        in_rst = 1'b0;
        chk("rst_full", 64'(out_full_cnt), 64'd0);
        chk("rst_wready", 64'(in_wready), 64'd1);
        chk("rst_avail", 64'(out_rd_avail), 64'd0);
        chk("rst_valid", 64'(out_rd_valid), 64'd0);
        chk("rst_err", 64'(out_rd_err), 64'd0);
        chk("rst_data", 64'(out_rdata), 64'd0);
        // buffer 0: i%4
        in_wvalid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_wdata = 2'(i % 4);
            step;
        end
        in_wvalid = 1'b0;
        chk("b0_full", 64'(out_full_cnt), 64'd1);
        chk("b0_avail", 64'(out_rd_avail), 64'd1);
        rd(8'd0, 1'b0, "idx0", 32'hE4E4E4E4);
        chk("idx0_err", 64'(out_rd_err), 64'd0);
        step;
        chk("hold_valid", 64'(out_rd_valid), 64'd0);
        chk("hold_data", 64'(out_rdata), 64'hE4E4E4E4);
        rd(8'hFD, 1'b0, "idxm3", 32'h39393900);
`ifdef FM_OOB_FLAG_EN
        chk("idxm3_oob", 64'(out_oob), 64'd1);
`endif
        in_rd_req = 1'b1;
        in_frag_idx = 8'd60;
        step;
        chk("idx60_valid", 64'(out_rd_valid), 64'd1);
        chk("idx60_data", 64'(out_rdata), 64'h000000E4);
`ifdef FM_OOB_FLAG_EN
        chk("idx60_oob", 64'(out_oob), 64'd1);
`endif
        in_frag_idx = 8'd48;
        step;
        chk("idx48_valid", 64'(out_rd_valid), 64'd1);
        chk("idx48_data", 64'(out_rdata), 64'hE4E4E4E4);
`ifdef FM_OOB_FLAG_EN
        chk("idx48_oob", 64'(out_oob), 64'd0);
`endif
        in_rd_req = 1'b0;
        rd(8'd62, 1'b0, "idx62", 32'h0000000E);
        // buffers 1..3 hold constant 1, 2, 3
        in_wvalid = 1'b1;
        for (int i = 0; i < 192; i++) begin
            in_wdata = 2'(1 + i / 64);
            step;
        end
        chk("ring_full", 64'(out_full_cnt), 64'd4);
        chk("ring_wready", 64'(in_wready), 64'd0);
        in_wdata = 2'd0;
        step;
        step;
        chk("stall_full", 64'(out_full_cnt), 64'd4);
        chk("stall_wready", 64'(in_wready), 64'd0);
        in_release = 1'b1;
        step;
        in_release = 1'b0;
        chk("rel1_full", 64'(out_full_cnt), 64'd3);
        chk("rel1_wready", 64'(in_wready), 64'd1);
        // refill buffer 0 with i%4, releasing on its last write
        for (int i = 0; i < 64; i++) begin
            in_wdata = 2'(i % 4);
            in_release = (i == 63);
            step;
        end
        in_release = 1'b0;
        in_wvalid = 1'b0;
        chk("both_full", 64'(out_full_cnt), 64'd3);
        rd(8'd0, 1'b1, "relreq", 32'hAAAAAAAA);
        chk("relreq_full", 64'(out_full_cnt), 64'd2);
        rd(8'd0, 1'b0, "b3", 32'hFFFFFFFF);
        in_release = 1'b1;
        step;
        in_release = 1'b0;
        chk("rel3_full", 64'(out_full_cnt), 64'd1);
        rd(8'd0, 1'b0, "b0new", 32'hE4E4E4E4);
        in_release = 1'b1;
        step;
        chk("empty_full", 64'(out_full_cnt), 64'd0);
        chk("empty_avail", 64'(out_rd_avail), 64'd0);
        step;
        in_release = 1'b0;
        chk("underflow_full", 64'(out_full_cnt), 64'd0);
        in_rd_req = 1'b1;
        step;
        in_rd_req = 1'b0;
        chk("err_err", 64'(out_rd_err), 64'd1);
        chk("err_valid", 64'(out_rd_valid), 64'd0);
        chk("err_data", 64'(out_rdata), 64'hE4E4E4E4);
        step;
        chk("err_pulse", 64'(out_rd_err), 64'd0);
        // partial buffer then reset
        in_wvalid = 1'b1;
        in_wdata = 2'd1;
        for (int i = 0; i < 30; i++) step;
        in_rst = 1'b1;
        step;
        in_rst = 1'b0;
        chk("mrst_full", 64'(out_full_cnt), 64'd0);
        chk("mrst_wready", 64'(in_wready), 64'd1);
        chk("mrst_valid", 64'(out_rd_valid), 64'd0);
        chk("mrst_data", 64'(out_rdata), 64'd0);
        in_wdata = 2'd3;
        for (int i = 0; i < 63; i++) step;
        chk("post_63", 64'(out_full_cnt), 64'd0);
        step;
        in_wvalid = 1'b0;
        chk("post_64", 64'(out_full_cnt), 64'd1);
        rd(8'd0, 1'b0, "post", 32'hFFFFFFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
